// File: rtl/row_load_controller.sv
// row_load_controller: stages host pixel writes into a one-row buffer and
// commits the full row into one segment block RAM with a single-cycle write.
//
// Build option: define COMMIT_SYNC_EN to hold each commit in COMMIT_WAIT
// until the next frame_start pulse (tear-free updates). Undefined (default):
// commit immediately, frame_start ignored.
//
// Ports:
//   clk, gls_reset     clock, synchronous active-high reset
//   wbm_address        {seg, row, col}; bit 15 on a read also clears err
//   wbm_writedata      pixel data, low PIXEL_WIDTH bits used
//   wbm_readdata       status {err, busy, 6'b0, fill_count[7:0]}
//   wbm_strobe/cycle/write, wbm_ack   Wishbone slave handshake
//   frame_start        display frame boundary pulse
//   ram_waddr          row address to all segment RAMs (always cur_row)
//   ram_in             live staging buffer, pixel c at [c*PW +: PW]
//   w_en               one-hot segment RAM write enable
//   busy               high while a commit is pending or in progress
module row_load_controller #(
    parameter int PIXEL_WIDTH   = 12,
    parameter int COL_ADDR_BITS = 6,
    parameter int ROW_ADDR_BITS = 4,
    parameter int SEGMENT_COUNT = 2
) (
    input  logic                                      clk,
    input  logic                                      gls_reset,
    input  logic [15:0]                               wbm_address,
    input  logic [15:0]                               wbm_writedata,
    output logic [15:0]                               wbm_readdata,
    input  logic                                      wbm_strobe,
    input  logic                                      wbm_cycle,
    input  logic                                      wbm_write,
    output logic                                      wbm_ack,
    input  logic                                      frame_start,
    output logic [ROW_ADDR_BITS-1:0]                  ram_waddr,
    output logic [(2**COL_ADDR_BITS)*PIXEL_WIDTH-1:0] ram_in,
    output logic [SEGMENT_COUNT-1:0]                  w_en,
    output logic                                      busy
);

    localparam int ROW_ELEM = 2**COL_ADDR_BITS;
    localparam int SEG_BITS = (SEGMENT_COUNT > 1) ? $clog2(SEGMENT_COUNT) : 1;
    localparam int RC_BITS  = ROW_ADDR_BITS + COL_ADDR_BITS;
    localparam int SEGF_W   = 16 - RC_BITS;

    typedef enum logic [1:0] {
        S_FILL        = 2'd0,
`ifdef COMMIT_SYNC_EN
        S_COMMIT_WAIT = 2'd1,
`endif
        S_COMMIT      = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     ack_q, ack_d;
    logic [15:0]              rdata_q, rdata_d;
    logic                     err_q, err_d;
    logic [7:0]               fill_q, fill_d;
    logic [SEG_BITS-1:0]      seg_q, seg_d;
    logic [ROW_ADDR_BITS-1:0] row_q, row_d;
    logic                     pend_q, pend_d;

    logic [PIXEL_WIDTH-1:0]   row_buf_q [ROW_ELEM];

    logic [COL_ADDR_BITS-1:0] a_col;
    logic [ROW_ADDR_BITS-1:0] a_row;
    logic [SEGF_W-1:0]        a_segf;
    logic [SEG_BITS-1:0]      a_seg;
    logic                     seg_ok;
    logic                     accept;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     buf_we;
    logic                     last_col;
    logic                     same_row;

    // Every address bit above {row, col} takes part in the segment range
    // check, so an out-of-range segment cannot alias onto a real one.
    assign a_col  = wbm_address[COL_ADDR_BITS-1:0];
    assign a_row  = wbm_address[RC_BITS-1:COL_ADDR_BITS];
    assign a_segf = wbm_address[15:RC_BITS];
    assign a_seg  = a_segf[SEG_BITS-1:0];
    assign seg_ok = a_segf < SEGF_W'(SEGMENT_COUNT);

    // No accept while ack is high, so a strobe held through the ack
    // cycle is not taken twice.
    assign accept   = wbm_cycle & wbm_strobe & ~ack_q & (state_q == S_FILL);
    assign wr_acc   = accept & wbm_write;
    assign rd_acc   = accept & ~wbm_write;
    assign buf_we   = wr_acc & seg_ok & ~gls_reset;
    assign last_col = (a_col == {COL_ADDR_BITS{1'b1}});
    assign same_row = ({a_seg, a_row} == {seg_q, row_q});

    assign busy         = (state_q != S_FILL);
    assign wbm_ack      = ack_q;
    assign wbm_readdata = rdata_q;
    assign ram_waddr    = row_q;

    // Gated by reset so a reset landing on the commit cycle drops the write.
    assign w_en = (state_q == S_COMMIT && !gls_reset)
                ? (SEGMENT_COUNT'(1) << seg_q)
                : '0;

    always_comb begin
        state_d = state_q;
        ack_d   = accept;
        rdata_d = rdata_q;
        err_d   = err_q;
        fill_d  = fill_q;
        seg_d   = seg_q;
        row_d   = row_q;
        pend_d  = pend_q;

        if (wr_acc) begin
            if (seg_ok) begin
                seg_d = a_seg;
                row_d = a_row;
                // A new target row restarts the count; old pixels stay.
                if (!same_row) begin
                    fill_d = 8'd1;
                end else if (fill_q < 8'(ROW_ELEM)) begin
                    fill_d = fill_q + 8'd1;
                end
                // Commit starts after the ack cycle: ack then w_en.
                if (last_col) begin
                    pend_d = 1'b1;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        if (rd_acc) begin
            rdata_d = {err_q, busy, 6'b0, fill_q};
            if (wbm_address[15]) begin
                err_d = 1'b0;
            end
        end

        unique case (state_q)
            S_FILL: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
`ifdef COMMIT_SYNC_EN
                    state_d = S_COMMIT_WAIT;
`else
                    state_d = S_COMMIT;
`endif
                end
            end
`ifdef COMMIT_SYNC_EN
            // Pulses seen before entry (e.g. on the last-column write)
            // do not count; only pulses while waiting release the commit.
            S_COMMIT_WAIT: begin
                if (frame_start) begin
                    state_d = S_COMMIT;
                end
            end
`endif
            S_COMMIT: begin
                state_d = S_FILL;
                fill_d  = 8'd0;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (gls_reset) begin
            state_q <= S_FILL;
            ack_q   <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
            fill_q  <= 8'd0;
            seg_q   <= '0;
            row_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
            seg_q   <= seg_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
        end
    end

    // Staging buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf_q[a_col] <= wbm_writedata[PIXEL_WIDTH-1:0];
        end
    end

    for (genvar c = 0; c < ROW_ELEM; c++) begin : g_pix
        assign ram_in[c*PIXEL_WIDTH +: PIXEL_WIDTH] = row_buf_q[c];
    end

    logic unused_wdata;
    assign unused_wdata = &{1'b0, wbm_writedata[15:PIXEL_WIDTH]};

`ifndef COMMIT_SYNC_EN
    logic unused_fs;
    assign unused_fs = frame_start;
`endif

endmodule

// File: tb/tb_row_load_controller.sv
// tb_row_load_controller: directed vectors for row_load_controller.
// Works with and without COMMIT_SYNC_EN defined.
module tb_row_load_controller;

    logic         clk = 1'b0;
    logic         gls_reset;
    logic [15:0]  wbm_address;
    logic [15:0]  wbm_writedata;
    logic [15:0]  wbm_readdata;
    logic         wbm_strobe;
    logic         wbm_cycle;
    logic         wbm_write;
    logic         wbm_ack;
    logic         frame_start;
    logic [3:0]   ram_waddr;
    logic [767:0] ram_in;
    logic [1:0]   w_en;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    row_load_controller dut (
        .clk           (clk),
        .gls_reset     (gls_reset),
        .wbm_address   (wbm_address),
        .wbm_writedata (wbm_writedata),
        .wbm_readdata  (wbm_readdata),
        .wbm_strobe    (wbm_strobe),
        .wbm_cycle     (wbm_cycle),
        .wbm_write     (wbm_write),
        .wbm_ack       (wbm_ack),
        .frame_start   (frame_start),
        .ram_waddr     (ram_waddr),
        .ram_in        (ram_in),
        .w_en          (w_en),
        .busy          (busy)
    );

    function automatic logic [15:0] adr(input int seg, input int row, input int col);
        return 16'((seg << 10) | (row << 6) | col);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [15:0] a, input logic [15:0] d, output int waited);
        wbm_address   = a;
        wbm_writedata = d;
        wbm_write     = 1'b1;
        wbm_cycle     = 1'b1;
        wbm_strobe    = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (wbm_ack !== 1'b1 && waited < 40);
        wbm_cycle  = 1'b0;
        wbm_strobe = 1'b0;
        wbm_write  = 1'b0;
        vectors++;
        if (wbm_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL write_ack_timeout addr=%h ack=%b want 1", a, wbm_ack);
        end
    endtask

    task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
        int waited;
        wbm_address = a;
        wbm_write   = 1'b0;
        wbm_cycle   = 1'b1;
        wbm_strobe  = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (wbm_ack !== 1'b1 && waited < 40);
        d = wbm_readdata;
        wbm_cycle  = 1'b0;
        wbm_strobe = 1'b0;
        vectors++;
        if (wbm_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL read_ack_timeout addr=%h ack=%b want 1", a, wbm_ack);
        end
    endtask

    // Called in the ack cycle of a last-column write; returns in the commit cycle.
    task automatic go_commit();
`ifdef COMMIT_SYNC_EN
        tick();
        vectors++;
        if (w_en !== 2'b00 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL commit_wait w_en=%b busy=%b want 00/1", w_en, busy);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic test_reset();
        logic [15:0] d;
        gls_reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if (wbm_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ack got %b want 0", wbm_ack);
        end
        vectors++;
        if (w_en !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_wen got %b want 00", w_en);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        vectors++;
        if (wbm_readdata !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_rdata got %h want 0000", wbm_readdata);
        end
        gls_reset = 1'b0;
        tick();
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_status got %h want 0000", d);
        end
        tick();
    endtask

    task automatic test_row_seg0();
        int w;
        int bad;
        logic [15:0]  d;
        logic [767:0] exp;
        bad = 0;
        for (int c = 0; c < 63; c++) begin
            wb_write(adr(0, 5, c), 16'(c), w);
            if (w != 1) bad++;
            tick();
            if (wbm_ack !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL seg0_single_acks got %0d bad want 0", bad);
        end
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'd63) begin
            miscompares++;
            $display("FAIL seg0_fill63 got %h want 003f", d);
        end
        tick();
        wb_write(adr(0, 5, 63), 16'd63, w);
        vectors++;
        if (w_en !== 2'b00) begin
            miscompares++;
            $display("FAIL seg0_wen_in_ack got %b want 00", w_en);
        end
        go_commit();
        for (int c = 0; c < 64; c++) exp[c*12 +: 12] = 12'(c);
        vectors++;
        if (w_en !== 2'b01) begin
            miscompares++;
            $display("FAIL seg0_wen got %b want 01", w_en);
        end
        vectors++;
        if (ram_waddr !== 4'd5 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL seg0_waddr_busy got %0d/%b want 5/1", ram_waddr, busy);
        end
        vectors++;
        if (ram_in !== exp) begin
            miscompares++;
            $display("FAIL seg0_ram_in got %h want %h", ram_in, exp);
        end
        tick();
        vectors++;
        if (w_en !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL seg0_after w_en=%b busy=%b want 00/0", w_en, busy);
        end
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h0000) begin
            miscompares++;
            $display("FAIL seg0_fill_clear got %h want 0000", d);
        end
        tick();
    endtask

    task automatic test_row_seg1();
        int w;
        logic [767:0] exp;
        for (int c = 0; c < 63; c++) begin
            wb_write(adr(1, 15, c), 16'h0ABC, w);
            tick();
        end
        wb_write(adr(1, 15, 63), 16'h0ABC, w);
        go_commit();
        for (int c = 0; c < 64; c++) exp[c*12 +: 12] = 12'hABC;
        vectors++;
        if (w_en !== 2'b10 || ram_waddr !== 4'd15) begin
            miscompares++;
            $display("FAIL seg1_commit got %b/%0d want 10/15", w_en, ram_waddr);
        end
        vectors++;
        if (ram_in !== exp) begin
            miscompares++;
            $display("FAIL seg1_ram_in got %h want %h", ram_in, exp);
        end
        tick();
    endtask

    task automatic test_bad_seg();
        int w;
        int bad;
        logic [15:0] d;
        wb_write(adr(2, 0, 63), 16'h0555, w);
        vectors++;
        if (w != 1) begin
            miscompares++;
            $display("FAIL badseg_ack got %0d cycles want 1", w);
        end
        bad = 0;
        repeat (4) begin
            tick();
            if (w_en !== 2'b00 || busy !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL badseg_no_commit got %0d bad cycles want 0", bad);
        end
        vectors++;
        if (ram_in[63*12 +: 12] !== 12'hABC) begin
            miscompares++;
            $display("FAIL badseg_discard got %h want abc", ram_in[63*12 +: 12]);
        end
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h8000) begin
            miscompares++;
            $display("FAIL badseg_err got %h want 8000", d);
        end
        tick();
        wb_read(16'h8000, d);
        vectors++;
        if (d !== 16'h8000) begin
            miscompares++;
            $display("FAIL badseg_clear_read got %h want 8000", d);
        end
        tick();
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h0000) begin
            miscompares++;
            $display("FAIL badseg_cleared got %h want 0000", d);
        end
        tick();
    endtask

    task automatic test_fill_restart();
        int w;
        logic [15:0] d;
        for (int c = 0; c < 10; c++) begin
            wb_write(adr(0, 3, c), 16'h0100 + 16'(c), w);
            tick();
        end
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h000A) begin
            miscompares++;
            $display("FAIL fill10 got %h want 000a", d);
        end
        tick();
        wb_write(adr(0, 4, 0), 16'h0200, w);
        tick();
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h0001) begin
            miscompares++;
            $display("FAIL fill_restart got %h want 0001", d);
        end
        tick();
    endtask

    task automatic test_stall();
        int w;
        logic [15:0] d;
`ifdef COMMIT_SYNC_EN
        int n;
        int bad;
        wb_write(adr(0, 4, 63), 16'h0123, w);
        wbm_address   = adr(0, 4, 1);
        wbm_writedata = 16'h0077;
        wbm_write     = 1'b1;
        wbm_cycle     = 1'b1;
        wbm_strobe    = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (wbm_ack !== 1'b0 || w_en !== 2'b00 || busy !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL sync_hold got %0d bad cycles want 0", bad);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vectors++;
        if (w_en !== 2'b01) begin
            miscompares++;
            $display("FAIL sync_commit got %b want 01", w_en);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (wbm_ack !== 1'b1 && n < 10);
        wbm_cycle  = 1'b0;
        wbm_strobe = 1'b0;
        wbm_write  = 1'b0;
        vectors++;
        if (wbm_ack !== 1'b1 || n != 2) begin
            miscompares++;
            $display("FAIL sync_stalled_ack got ack=%b after %0d want 1 after 2", wbm_ack, n);
        end
`else
        wb_write(adr(0, 4, 63), 16'h0123, w);
        wb_write(adr(0, 4, 1), 16'h0077, w);
        vectors++;
        if (w != 3) begin
            miscompares++;
            $display("FAIL stall_ack got %0d cycles want 3", w);
        end
`endif
        tick();
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h0001) begin
            miscompares++;
            $display("FAIL stall_fill got %h want 0001", d);
        end
        tick();
    endtask

    task automatic test_reset_commit();
        int w;
        logic [15:0] d;
        wb_write(adr(0, 7, 63), 16'h03C3, w);
        go_commit();
        vectors++;
        if (w_en !== 2'b01 || ram_waddr !== 4'd7) begin
            miscompares++;
            $display("FAIL rst_commit_pre got %b/%0d want 01/7", w_en, ram_waddr);
        end
        gls_reset = 1'b1;
        #1;
        vectors++;
        if (w_en !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_commit_wen got %b want 00", w_en);
        end
        tick();
        gls_reset = 1'b0;
        vectors++;
        if (w_en !== 2'b00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_commit_after w_en=%b busy=%b want 00/0", w_en, busy);
        end
        tick();
        wb_read(16'h0000, d);
        vectors++;
        if (d !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_commit_fill got %h want 0000", d);
        end
        tick();
    endtask

    initial begin
        gls_reset     = 1'b1;
        wbm_address   = 16'h0000;
        wbm_writedata = 16'h0000;
        wbm_strobe    = 1'b0;
        wbm_cycle     = 1'b0;
        wbm_write     = 1'b0;
        frame_start   = 1'b0;
        tick();
        test_reset();
        test_row_seg0();
        test_row_seg1();
        test_bad_seg();
        test_fill_restart();
        test_stall();
        test_reset_commit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
